// File: rtl/fma_memory.sv
// fma_memory: line-oriented operand memory (BRAM, address register, staging line) feeding the FMA array.
// Optional LOADS_AUTO_STORE_EN: LOADS also writes the updated staging line to BRAM[addr].
module fma_memory #(
    parameter int FMA_COUNT         = 2,
    parameter int WORD_WIDTH        = 16,
    parameter int LINE_WIDTH        = FMA_COUNT * 3 * WORD_WIDTH,
    parameter int ADDR_LENGTH       = 9,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [WORD_WIDTH-1:0]        controller_reg_a,
    input  logic [WORD_WIDTH-1:0]        controller_reg_b,
    input  logic [WORD_WIDTH-1:0]        controller_reg_c,
    input  logic [LINE_WIDTH-1:0]        write_buffer_read_in,
    input  logic                         write_buffer_valid_in,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
    input  logic                         instr_valid_in,
    output logic [LINE_WIDTH-1:0]        abc_out,
    output logic                         use_new_c_out,
    output logic                         fma_output_can_be_valid_out,
    output logic                         abc_valid_out
);
    localparam int WORDS = 3 * FMA_COUNT;
    localparam logic [3:0] OP_SETADDR = 4'b0111;
    localparam logic [3:0] OP_LOADS   = 4'b1101;
    localparam logic [3:0] OP_LOADW   = 4'b0110;
    localparam logic [3:0] OP_STORE   = 4'b1110;
    localparam logic [3:0] OP_WB      = 4'b1010;
    localparam logic [3:0] OP_READ    = 4'b1100;

    logic [3:0]             op, x;
    logic [1:0]             s;
    logic [WORD_WIDTH-1:0]  imm, sel;
    logic                   is_setaddr, is_loads, is_loadw, is_store, is_wb, is_read, wr_en;
    logic [LINE_WIDTH-1:0]  stage_q, stage_nxt, wr_data, bram_q, p2_q;
    logic [ADDR_LENGTH-1:0] addr_q, p0_addr;
    logic                   p0_v, p1_v, p2_v;
    logic [1:0]             p0_f, p1_f, p2_f;
    logic [LINE_WIDTH-1:0]  mem [2**ADDR_LENGTH];

    assign op  = instr_in[31:28];
    assign x   = instr_in[27:24];
    assign imm = instr_in[23:8];
    assign s   = x[1:0];
    assign sel = s == 2'd0 ? controller_reg_a : s == 2'd1 ? controller_reg_b : controller_reg_c;

    assign is_setaddr = instr_valid_in && op == OP_SETADDR;
    assign is_loads   = instr_valid_in && op == OP_LOADS && s != 2'd3;
    assign is_loadw   = instr_valid_in && op == OP_LOADW && int'(x) < WORDS;
    assign is_store   = instr_valid_in && op == OP_STORE;
    assign is_wb      = instr_valid_in && op == OP_WB;
    assign is_read    = instr_valid_in && op == OP_READ;

    always_comb begin
        stage_nxt = stage_q;
        for (int i = 0; i < FMA_COUNT; i++)
            if (is_loads)
                stage_nxt[LINE_WIDTH-1-(3*i+int'(s))*WORD_WIDTH -: WORD_WIDTH] = sel + imm * WORD_WIDTH'(i);
        if (is_loadw)
            stage_nxt[LINE_WIDTH-1-int'(x)*WORD_WIDTH -: WORD_WIDTH] = imm;
    end

`ifdef LOADS_AUTO_STORE_EN
    assign wr_en = is_store || (is_wb && write_buffer_valid_in) || is_loads;
`else
    assign wr_en = is_store || (is_wb && write_buffer_valid_in);
`endif
    assign wr_data = is_wb ? write_buffer_read_in : stage_nxt;

    // BRAM stays reset-free; a read issued after a write sees it since the array read happens one edge later
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[addr_q] <= wr_data;
        bram_q <= mem[p0_addr];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr_q                      <= '0;
            stage_q                     <= '0;
            p0_v                        <= 1'b0;
            p0_addr                     <= '0;
            p0_f                        <= '0;
            p1_v                        <= 1'b0;
            p1_f                        <= '0;
            p2_v                        <= 1'b0;
            p2_f                        <= '0;
            p2_q                        <= '0;
            abc_out                     <= '0;
            abc_valid_out               <= 1'b0;
            use_new_c_out               <= 1'b0;
            fma_output_can_be_valid_out <= 1'b0;
        end else begin
            if (is_setaddr) addr_q <= imm[ADDR_LENGTH-1:0];
            stage_q                     <= stage_nxt;
            p0_v                        <= is_read;
            p0_addr                     <= addr_q;
            p0_f                        <= instr_in[5:4];
            p1_v                        <= p0_v;
            p1_f                        <= p0_f;
            p2_v                        <= p1_v;
            p2_f                        <= p1_f;
            p2_q                        <= bram_q;
            abc_valid_out               <= p2_v;
            use_new_c_out               <= p2_v & p2_f[0];
            fma_output_can_be_valid_out <= p2_v & p2_f[1];
            if (p2_v) abc_out <= p2_q;
        end
    end
endmodule

// File: tb/tb_fma_memory.sv
// tb_fma_memory: table vectors, reset sequences and random instructions checked against a queue-based model.
module tb_fma_memory;
    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic [15:0]  controller_reg_a = '0, controller_reg_b = '0, controller_reg_c = '0;
    logic [95:0]  write_buffer_read_in = '0;
    logic         write_buffer_valid_in = 1'b0;
    logic [31:0]  instr_in = '0;
    logic         instr_valid_in = 1'b0;
    logic [95:0]  abc_out;
    logic         use_new_c_out, fma_output_can_be_valid_out, abc_valid_out;

    fma_memory dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .controller_reg_a(controller_reg_a), .controller_reg_b(controller_reg_b),
        .controller_reg_c(controller_reg_c),
        .write_buffer_read_in(write_buffer_read_in), .write_buffer_valid_in(write_buffer_valid_in),
        .instr_in(instr_in), .instr_valid_in(instr_valid_in),
        .abc_out(abc_out), .use_new_c_out(use_new_c_out),
        .fma_output_can_be_valid_out(fma_output_can_be_valid_out), .abc_valid_out(abc_valid_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { int due; logic [95:0] d; logic [1:0] f; } rd_t;
    typedef struct {
        logic [31:0] ins; logic [95:0] wb; logic wbv;
        logic chk; logic ev; logic [95:0] eabc; logic eu; logic ef;
    } vec_t;

    int          n_tests = 0, n_fail = 0, cyc = 0;
    rd_t         q[$];
    vec_t        tv[$];
    logic [95:0] mem_m [512];
    logic [15:0] st [6];
    logic [8:0]  addr_m = '0;

    function automatic logic [31:0] enc(logic [3:0] op, logic [3:0] x, logic [15:0] imm, logic [3:0] y);
        return {op, x, imm, y, 4'h0};
    endfunction

    function automatic logic [95:0] pat(int k);
        logic [95:0] r;
        for (int w = 0; w < 6; w++) r[95-16*w -: 16] = 16'(k * 257 + w * 4369 + 4096);
        return r;
    endfunction

    function automatic logic [95:0] stage_line();
        logic [95:0] r;
        for (int w = 0; w < 6; w++) r[95-16*w -: 16] = st[w];
        return r;
    endfunction

    task automatic cmp(input string nm, input logic [98:0] act, input logic [98:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [98:0] outs();
        return {abc_valid_out, use_new_c_out, fma_output_can_be_valid_out, abc_valid_out ? abc_out : 96'h0};
    endfunction

    task automatic model_apply();
        logic [3:0]  op  = instr_in[31:28];
        logic [3:0]  x   = instr_in[27:24];
        logic [15:0] imm = instr_in[23:8];
        logic [15:0] rv;
        if (!instr_valid_in) return;
        rv = x[1:0] == 2'd0 ? controller_reg_a : x[1:0] == 2'd1 ? controller_reg_b : controller_reg_c;
        case (op)
            4'h7: addr_m = imm[8:0];
            4'hD: if (x[1:0] != 2'd3) begin
                for (int i = 0; i < 2; i++) st[3*i + int'(x[1:0])] = rv + 16'(i) * imm;
`ifdef LOADS_AUTO_STORE_EN
                mem_m[addr_m] = stage_line();
`endif
            end
            4'h6: if (x < 4'd6) st[x] = imm;
            4'hE: mem_m[addr_m] = stage_line();
            4'hA: if (write_buffer_valid_in) mem_m[addr_m] = write_buffer_read_in;
            4'hC: q.push_back('{cyc + 3, mem_m[addr_m], instr_in[5:4]});
            default: ;
        endcase
    endtask

    task automatic check_model();
        logic [98:0] exp = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp = {1'b1, q[0].f[0], q[0].f[1], q[0].d};
            void'(q.pop_front());
        end
        cmp("pipeline", outs(), exp);
    endtask

    task automatic step(input logic [31:0] ins, input logic iv, input logic [95:0] wb, input logic wbv);
        instr_in = ins;
        instr_valid_in = iv;
        write_buffer_read_in = wb;
        write_buffer_valid_in = wbv;
        @(posedge clk_in);
        cyc++;
        model_apply();
        #1 check_model();
    endtask

    task automatic do_reset(input int n);
        rst_in = 1'b0;
        instr_valid_in = 1'b0;
        q.delete();
        addr_m = '0;
        for (int i = 0; i < 6; i++) st[i] = '0;
        #1 cmp("async_reset", {abc_valid_out, use_new_c_out, fma_output_can_be_valid_out, abc_out}, '0);
        repeat (n) begin
            @(posedge clk_in);
            cyc++;
            #1 cmp("in_reset", {abc_valid_out, use_new_c_out, fma_output_can_be_valid_out, abc_out}, '0);
        end
        rst_in = 1'b1;
    endtask

    task automatic add(input logic [31:0] ins, input logic [95:0] wb, input logic wbv,
                       input logic chk, input logic ev, input logic [95:0] eabc, input logic eu, input logic ef);
        tv.push_back('{ins, wb, wbv, chk, ev, eabc, eu, ef});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] nop, st_i;
        logic [95:0] wline, l1, l2;
        logic [3:0]  bad_ops [9];
        nop   = 32'h0;
        st_i  = enc(4'hE, 0, 0, 0);
        wline = 96'hAA00_A000_A000_A000_A000_A000;
        l1    = 96'h0001_0000_0000_0002_0000_0000;
        l2    = 96'h0001_0000_0003_0002_0000_0002;
        bad_ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB, 4'hF};
        #2 do_reset(2);
        for (int k = 0; k < 16; k++) begin
            step(enc(4'h7, 0, 16'(k), 0), 1'b1, '0, 1'b0);
            step(enc(4'hA, 0, 0, 0), 1'b1, pat(k), 1'b1);
        end
        // reset, then a READ straight away; lines 3 and 4 read back-to-back later on
        add(enc(4'hC, 0, 0, 0),       '0, 0, 1, 0, '0, 0, 0);
        add(nop,                      '0, 0, 1, 0, '0, 0, 0);
        add(nop,                      '0, 0, 1, 0, '0, 0, 0);
        add(enc(4'h7, 0, 16'd8, 0),   '0, 0, 1, 1, pat(0), 0, 0);
        add(enc(4'hD, 4'd0, 16'd1, 0), '0, 0, 0, 0, '0, 0, 0);
        add(st_i,                     '0, 0, 0, 0, '0, 0, 0);
        add(enc(4'hC, 0, 0, 0),       '0, 0, 0, 0, '0, 0, 0);
        add(nop,                      '0, 0, 0, 0, '0, 0, 0);
        add(nop,                      '0, 0, 0, 0, '0, 0, 0);
        add(enc(4'hD, 4'd2, 16'hFFFF, 0), '0, 0, 1, 1, l1, 0, 0);
        add(st_i,                     '0, 0, 0, 0, '0, 0, 0);
        add(enc(4'hC, 0, 0, 0),       '0, 0, 0, 0, '0, 0, 0);
        add(enc(4'h7, 0, 16'd5, 0),   '0, 0, 0, 0, '0, 0, 0);
        add(enc(4'hA, 0, 0, 0),       wline, 1, 0, 0, '0, 0, 0);
        add(enc(4'hC, 0, 0, 4'd3),    '0, 0, 1, 1, l2, 0, 0);
        add(enc(4'hA, 0, 0, 0),       96'h1234_5678_9ABC_DEF0_1357_2468, 0, 0, 0, '0, 0, 0);
        add(enc(4'hC, 0, 0, 0),       '0, 0, 0, 0, '0, 0, 0);
        add(enc(4'h7, 0, 16'd3, 0),   '0, 0, 1, 1, wline, 1, 1);
        add(enc(4'hC, 0, 0, 4'd1),    '0, 0, 0, 0, '0, 0, 0);
        add(enc(4'hC, 0, 0, 4'd2),    '0, 0, 1, 1, wline, 0, 0);
        add(enc(4'h7, 0, 16'd4, 0),   '0, 0, 1, 0, '0, 0, 0);
        add(enc(4'hC, 0, 0, 0),       '0, 0, 1, 1, pat(3), 1, 0);
        add(enc(4'hC, 0, 0, 0),       '0, 0, 1, 1, pat(3), 0, 1);
        add(nop,                      '0, 0, 1, 0, '0, 0, 0);
        add(nop,                      '0, 0, 1, 1, pat(4), 0, 0);
        add(nop,                      '0, 0, 1, 1, pat(4), 0, 0);
        add(nop,                      '0, 0, 1, 0, '0, 0, 0);
        do_reset(1);
        controller_reg_a = 16'd1;
        controller_reg_b = 16'd2;
        controller_reg_c = 16'd3;
        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].ins, 1'b1, tv[i].wb, tv[i].wbv);
            if (tv[i].chk)
                cmp($sformatf("vec%0d", i), outs(), {tv[i].ev, tv[i].eu, tv[i].ef, tv[i].eabc});
        end
        // reset one cycle after a READ: the in-flight read must vanish and addr must return to 0
        step(enc(4'h7, 0, 16'd2, 0), 1'b1, '0, 1'b0);
        step(enc(4'hC, 0, 0, 4'd3), 1'b1, '0, 1'b0);
        do_reset(2);
        repeat (5) step(nop, 1'b1, '0, 1'b0);
        step(enc(4'hC, 0, 0, 0), 1'b1, '0, 1'b0);
        repeat (3) step(nop, 1'b1, '0, 1'b0);
        cmp("addr_after_reset", outs(), {3'b100, pat(0)});
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            int          c = $urandom_range(0, 8);
            controller_reg_a = 16'($urandom);
            controller_reg_b = 16'($urandom);
            controller_reg_c = 16'($urandom);
            ins = c == 1 ? enc(4'h7, 4'($urandom), 16'($urandom) & 16'hFE0F, 4'($urandom)) :
                  c == 2 ? enc(4'hD, 4'($urandom), 16'($urandom), 4'($urandom)) :
                  c == 3 ? enc(4'h6, 4'($urandom), 16'($urandom), 4'($urandom)) :
                  c == 4 ? enc(4'hE, 4'($urandom), 16'($urandom), 4'($urandom)) :
                  c == 5 ? enc(4'hA, 4'($urandom), 16'($urandom), 4'($urandom)) :
                  c >= 6 && c <= 7 ? enc(4'hC, 4'($urandom), 16'($urandom), 4'($urandom)) :
                  c == 8 ? enc(bad_ops[$urandom_range(0, 8)], 4'($urandom), 16'($urandom), 4'($urandom)) :
                  32'h0;
            step(ins, $urandom_range(0, 9) != 0, {$urandom, $urandom, $urandom}, 1'($urandom));
        end
        repeat (4) step(nop, 1'b0, '0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fma_memory.md
Name: fma_memory

Overview:
- Line-oriented operand memory feeding the FMA array.
- Holds a BRAM of LINE_WIDTH-bit lines, an address register and a staging line, all driven by 32-bit instructions from the controller.
- Assembles per-FMA a/b/c operands as broadcast-plus-stride values from controller registers, stores and fetches lines, and writes FMA results back.
- Fetched lines are presented to the FMAs on abc_out.

Parameters:
- FMA_COUNT, 2: FMAs served per line.
- WORD_WIDTH, 16: bits per word.
- LINE_WIDTH, 96: FMA_COUNT*3*WORD_WIDTH.
- ADDR_LENGTH, 9: line address bits; BRAM depth is 2**ADDR_LENGTH lines.
- INSTRUCTION_WIDTH, 32: instruction bits.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: reset; asynchronous, active-low.
- controller_reg_a, input, 16: controller register value for slot a.
- controller_reg_b, input, 16: controller register value for slot b.
- controller_reg_c, input, 16: controller register value for slot c.
- write_buffer_read_in, input, LINE_WIDTH: FMA result line to write back.
- write_buffer_valid_in, input, 1: write_buffer_read_in is valid.
- instr_in, input, INSTRUCTION_WIDTH: instruction.
- instr_valid_in, input, 1: instruction valid; one instruction per cycle.
- abc_out, output, LINE_WIDTH: fetched operand line.
- use_new_c_out, output, 1: FMA should take c from abc_out.
- fma_output_can_be_valid_out, output, 1: FMA results of this operation may be consumed.
- abc_valid_out, output, 1: abc_out valid (one-cycle pulse).

Behaviour:
- Line layout: word k occupies bits [LINE_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH], so word 0 is at the MSB. FMA i owns a=word 3i, b=word 3i+1, c=word 3i+2.
- Instruction fields: OP=[31:28], X=[27:24], IMM=[23:8], Y=[7:4], Z=[3:0]. Instructions are ignored when instr_valid_in=0. Undefined OP is treated as NOP.
- 0000 NOP: no effect.
- 0111 SETADDR: addr <= IMM[ADDR_LENGTH-1:0]; effective for the next instruction.
- 1101 LOADS: X[1:0] selects slot s (0=a/reg_a, 1=b/reg_b, 2=c/reg_c); X[1:0]=3 is a NOP. For every FMA i, staging word 3i+s <= reg_s + i*IMM, truncated mod 2**16. Other staging words are unchanged.
- 0110 LOADW: staging word X <= IMM. X>=3*FMA_COUNT is ignored.
- 1110 STORE: BRAM[addr] <= staging line.
- 1010 WRITEBACK: BRAM[addr] <= write_buffer_read_in, only if write_buffer_valid_in=1; otherwise dropped.
- 1100 READ: issues a read of BRAM[addr]. The BRAM takes 2 cycles, plus 1 output register, so a READ accepted on edge N gives abc_out and abc_valid_out=1 after edge N+3. abc_valid_out lasts one cycle.
- READ flags: use_new_c_out=Y[0] and fma_output_can_be_valid_out=Y[1] are captured with the READ and pipelined to align with abc_valid_out; both are 0 when abc_valid_out=0.
- READ pipelining: back-to-back READs are fully pipelined, one result per cycle in issue order.
- Read-after-write: a READ issued the cycle after a STORE or WRITEBACK to the same address returns the new data.
- Reset (rst_in=0, asynchronous): clears all outputs, addr, the staging line and the read pipeline. An in-flight READ produces no valid pulse. BRAM contents are not cleared.

Optional Feature:
- Macro LOADS_AUTO_STORE_EN.
- When defined: LOADS also writes the updated staging line to BRAM[addr] in the same cycle, so no separate STORE is needed.
- When undefined: LOADS touches only the staging line.

Test Plan:
- Reset, then READ of addr 0 issued immediately -> abc_valid_out stays 0 until 3 cycles later, and no spurious pulses while rst_in=0.
- reg_a=1, reg_b=2, reg_c=3; SETADDR 8; LOADS X=0 IMM=1; STORE; READ -> abc_out=0x0001_0000_0000_0002_0000_0000, valid 3 cycles after READ.
- LOADS X=2 IMM=0xFFFF with reg_c=3, then STORE and READ -> c words are 0x0003 and 0x0002 (wrap mod 2**16).
- SETADDR 5; WRITEBACK with buffer=0xAA00_A000_A000_A000_A000_A000 and valid=1; READ Y=3 -> that line with use_new_c_out=1 and fma_output_can_be_valid_out=1. Repeat WRITEBACK with valid=0 -> line unchanged.
- Two consecutive READs of lines 3 and 4 -> abc_valid_out high on two consecutive cycles with data in order.
- rst_in asserted one cycle after a READ -> no abc_valid_out pulse; addr reads back as 0.
